// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS control FSM and its output decoder:
// state codes, opcodes, ALU request codes, ALU B-operand selects and the control vector.
package mips_ctrl_pkg;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_ALU_WB   = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WB   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  localparam logic [1:0] CLASS_R = 2'b00;
  localparam logic [1:0] CLASS_I = 2'b01;

  localparam logic [5:0] OP_LW   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100001;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_J    = 6'b110010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_FUNC = 4'b0010;

  localparam logic [1:0] SRCB_ONE   = 2'd0;
  localparam logic [1:0] SRCB_REG_B = 2'd1;
  localparam logic [1:0] SRCB_JUMP  = 2'd2;
  localparam logic [1:0] SRCB_IMM   = 2'd3;

  typedef struct packed {
    logic       pc_source;
    logic       pc_write;
    logic       beq_control;
    logic       bne_control;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ir_write;
    logic       rf_write;
    logic       mdr_write;
    logic       dmem_write;
    logic       mem_to_reg;
    logic       immed_addr;
    logic       read_data_src1;
    logic       read_data_src2;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op[5:4] == CLASS_R) || (op[5:4] == CLASS_I) ||
           (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_J) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
interface multicycle_controller_if #(
  parameter int OpcodeSize = 6,
  parameter int ALUOpSize  = 4,
  parameter int CountSize  = 16
);
  logic [OpcodeSize-1:0] Opcode;
  logic                  PCSource;
  logic                  PCWrite;
  logic                  BEQcontrol;
  logic                  BNEcontrol;
  logic [ALUOpSize-1:0]  AluOp;
  logic                  AluSrcA;
  logic [1:0]            AluSrcB;
  logic                  IRWrite;
  logic                  RFWrite;
  logic                  MDRWrite;
  logic                  DMemWrite;
  logic                  MemToReg;
  logic                  ImmedAddr;
  logic                  ReadDataSrc1;
  logic                  ReadDataSrc2;
  logic                  Halted;
  logic                  IllegalOp;
  logic [CountSize-1:0]  InstrRetired;

  modport master (
    input  Opcode,
    output PCSource, PCWrite, BEQcontrol, BNEcontrol, AluOp, AluSrcA, AluSrcB,
           IRWrite, RFWrite, MDRWrite, DMemWrite, MemToReg, ImmedAddr,
           ReadDataSrc1, ReadDataSrc2, Halted, IllegalOp, InstrRetired
  );

  modport slave (
    output Opcode,
    input  PCSource, PCWrite, BEQcontrol, BNEcontrol, AluOp, AluSrcA, AluSrcB,
           IRWrite, RFWrite, MDRWrite, DMemWrite, MemToReg, ImmedAddr,
           ReadDataSrc1, ReadDataSrc2, Halted, IllegalOp, InstrRetired
  );
endinterface

// File: rtl/multicycle_controller_decode.sv
// Combinational state + opcode to datapath control-vector decoder.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  logic is_r;
  logic is_i;

  assign is_r = (opcode_i[5:4] == CLASS_R);
  assign is_i = (opcode_i[5:4] == CLASS_I);

  always_comb begin
    ctrl_o = '0;
    // Register-file read selects follow the IR in every active state.
    if (state_i != S_IDLE) begin
      ctrl_o.read_data_src1 = is_r || is_i || (opcode_i == OP_LW);
      ctrl_o.read_data_src2 = is_r;
    end
    case (state_i)
      S_FETCH: begin
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_ONE;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG_B;
        ctrl_o.alu_op    = ALU_FUNC;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_FUNC;
      end
      S_ALU_WB: ctrl_o.rf_write = 1'b1;
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.immed_addr = 1'b1;
        ctrl_o.mdr_write  = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.rf_write   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.immed_addr = 1'b1;
        ctrl_o.dmem_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a   = 1'b1;
        ctrl_o.alu_src_b   = SRCB_REG_B;
        ctrl_o.alu_op      = ALU_SUB;
        ctrl_o.pc_source   = 1'b1;
        ctrl_o.beq_control = (opcode_i == OP_BEQ);
        ctrl_o.bne_control = (opcode_i == OP_BNE);
      end
      S_JUMP: begin
        ctrl_o.alu_src_b = SRCB_JUMP;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: state register, next-state logic, sticky halt/illegal
// status and the retired-instruction counter; control outputs come from ctrl_output_decode.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int OpcodeSize = 6,
  parameter int ALUOpSize  = 4,
  parameter int CountSize  = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  multicycle_controller_if.master bus
);

  logic [3:0]           state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic                 halt_retired_q;
  logic [CountSize-1:0] count_q;
  logic                 retire;
  logic [5:0]           opcode;
  ctrl_t                ctrl;

  assign opcode = 6'(bus.Opcode);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (opcode[5:4] == CLASS_R)                     state_d = S_EXEC_R;
        else if (opcode[5:4] == CLASS_I)                state_d = S_EXEC_I;
        else if (opcode == OP_LW || opcode == OP_SW)    state_d = S_MEM_ADDR;
        else if (opcode == OP_BEQ || opcode == OP_BNE)  state_d = S_BRANCH;
        else if (opcode == OP_J)                        state_d = S_JUMP;
        else if (opcode == OP_HALT)                     state_d = S_HALT;
        else                                            state_d = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
  end

  assign illegal_d = illegal_q || ((state_q == S_DECODE) && !op_is_legal(opcode));

  // HALT counts once, on its first cycle; it never leaves except through reset.
  assign retire = (state_q inside {S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP}) ||
                  ((state_q == S_HALT) && !halt_retired_q);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= S_IDLE;
      illegal_q      <= 1'b0;
      halt_retired_q <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      illegal_q      <= illegal_d;
      halt_retired_q <= halt_retired_q || (state_q == S_HALT);
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  ctrl_output_decode u_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .ctrl_o   (ctrl)
  );

  assign bus.PCSource     = ctrl.pc_source;
  assign bus.PCWrite      = ctrl.pc_write;
  assign bus.BEQcontrol   = ctrl.beq_control;
  assign bus.BNEcontrol   = ctrl.bne_control;
  assign bus.AluOp        = ALUOpSize'(ctrl.alu_op);
  assign bus.AluSrcA      = ctrl.alu_src_a;
  assign bus.AluSrcB      = ctrl.alu_src_b;
  assign bus.IRWrite      = ctrl.ir_write;
  assign bus.RFWrite      = ctrl.rf_write;
  assign bus.MDRWrite     = ctrl.mdr_write;
  assign bus.DMemWrite    = ctrl.dmem_write;
  assign bus.MemToReg     = ctrl.mem_to_reg;
  assign bus.ImmedAddr    = ctrl.immed_addr;
  assign bus.ReadDataSrc1 = ctrl.read_data_src1;
  assign bus.ReadDataSrc2 = ctrl.read_data_src2;
  assign bus.Halted       = (state_q == S_HALT);
  assign bus.IllegalOp    = illegal_q;
  assign bus.InstrRetired = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: an instruction-level model predicts every output each cycle;
// a few literal pins fix key values independently of the model.
module tb_multicycle_controller;

  localparam int CW = 4;

  localparam logic [5:0] T_R    = 6'b000010;
  localparam logic [5:0] T_I    = 6'b010011;
  localparam logic [5:0] T_LW   = 6'b100000;
  localparam logic [5:0] T_SW   = 6'b100001;
  localparam logic [5:0] T_BEQ  = 6'b110000;
  localparam logic [5:0] T_BNE  = 6'b110001;
  localparam logic [5:0] T_J    = 6'b110010;
  localparam logic [5:0] T_HALT = 6'b111111;
  localparam logic [5:0] T_BAD  = 6'b101111;
  localparam int HALT_CYCLES = 20;

  typedef struct packed {
    logic          pcsrc, pcw, beq, bne;
    logic [3:0]    aluop;
    logic          srca;
    logic [1:0]    srcb;
    logic          irw, rfw, mdrw, dmw, m2r, imm, rd1, rd2, halted, illegal;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef enum int {P_COUNT, P_ILLEGAL, P_HALTED, P_BEQ, P_BNE, P_RFWRITE, P_MDR} pin_e;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  multicycle_controller_if #(.OpcodeSize(6), .ALUOpSize(4), .CountSize(CW)) bus ();

  multicycle_controller #(.OpcodeSize(6), .ALUOpSize(4), .CountSize(CW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  exp_t       exp_now;
  logic       exp_valid = 1'b0;
  logic       pin_valid = 1'b0;
  pin_e       pin_sel = P_COUNT;
  int         pin_val = 0;
  int         checks = 0;
  int         errors = 0;
  event       chk_ev;

  logic [5:0]    m_prev;
  logic [CW-1:0] m_cnt;
  logic          m_ill;

  function automatic bit legal(input logic [5:0] op);
    return (op[5:4] == 2'b00) || (op[5:4] == 2'b01) || op == T_LW || op == T_SW ||
           op == T_BEQ || op == T_BNE || op == T_J || op == T_HALT;
  endfunction

  function automatic int instr_len(input logic [5:0] op);
    if (!legal(op))                               return 2;
    if (op == T_HALT)                             return 2 + HALT_CYCLES;
    if (op == T_LW)                               return 5;
    if (op == T_BEQ || op == T_BNE || op == T_J)  return 3;
    return 4;
  endfunction

  // Expected outputs for step s of an instruction (step 0 = FETCH).
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] prev, input int s,
                                 input logic [CW-1:0] cnt, input logic ill);
    exp_t e;
    logic [5:0] src;
    e = '0;
    src = (s == 0) ? prev : op;
    e.rd1 = (src[5:4] == 2'b00) || (src[5:4] == 2'b01) || (src == T_LW);
    e.rd2 = (src[5:4] == 2'b00);
    e.illegal = ill;
    e.cnt = (op == T_HALT && s >= 3) ? CW'(cnt + 1'b1) : cnt;
    if (s == 0) begin
      e.irw = 1'b1; e.pcw = 1'b1;
    end else if (s == 1) begin
      e.srcb = 2'd3;
    end else if (op == T_HALT) begin
      e.halted = 1'b1;
    end else if (op[5:4] == 2'b00 || op[5:4] == 2'b01) begin
      if (s == 2) begin
        e.srca = 1'b1; e.aluop = 4'd2;
        e.srcb = (op[5:4] == 2'b00) ? 2'd1 : 2'd3;
      end else e.rfw = 1'b1;
    end else if (op == T_LW || op == T_SW) begin
      if (s == 2) begin
        e.srca = 1'b1; e.srcb = 2'd3;
      end else if (s == 3) begin
        e.imm = 1'b1;
        if (op == T_LW) e.mdrw = 1'b1; else e.dmw = 1'b1;
      end else begin
        e.rfw = 1'b1; e.m2r = 1'b1;
      end
    end else if (op == T_BEQ || op == T_BNE) begin
      e.srca = 1'b1; e.srcb = 2'd1; e.aluop = 4'd1; e.pcsrc = 1'b1;
      e.beq = (op == T_BEQ); e.bne = (op == T_BNE);
    end else if (op == T_J) begin
      e.srcb = 2'd2; e.pcw = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t dut_vec();
    exp_t g;
    g.pcsrc = bus.PCSource;   g.pcw = bus.PCWrite;  g.beq = bus.BEQcontrol; g.bne = bus.BNEcontrol;
    g.aluop = bus.AluOp;      g.srca = bus.AluSrcA; g.srcb = bus.AluSrcB;   g.irw = bus.IRWrite;
    g.rfw = bus.RFWrite;      g.mdrw = bus.MDRWrite; g.dmw = bus.DMemWrite; g.m2r = bus.MemToReg;
    g.imm = bus.ImmedAddr;    g.rd1 = bus.ReadDataSrc1; g.rd2 = bus.ReadDataSrc2;
    g.halted = bus.Halted;    g.illegal = bus.IllegalOp; g.cnt = bus.InstrRetired;
    return g;
  endfunction

  function automatic int pin_value(input pin_e p);
    case (p)
      P_COUNT:   return int'(bus.InstrRetired);
      P_ILLEGAL: return int'(bus.IllegalOp);
      P_HALTED:  return int'(bus.Halted);
      P_BEQ:     return int'(bus.BEQcontrol);
      P_BNE:     return int'(bus.BNEcontrol);
      P_RFWRITE: return int'(bus.RFWrite);
      default:   return int'(bus.MDRWrite);
    endcase
  endfunction

  // Single compare process: model vector every cycle, plus any literal pin.
  initial begin
    exp_t g;
    int v;
    forever begin
      @(negedge Clk or chk_ev);
      if (exp_valid) begin
        g = dut_vec();
        checks++;
        if (g !== exp_now) begin
          errors++;
          $display("FAIL outputs t=%0t: got %h required %h", $time, g, exp_now);
        end
        if (pin_valid) begin
          v = pin_value(pin_sel);
          checks++;
          if (v != pin_val) begin
            errors++;
            $display("FAIL pin %s t=%0t: got %0d required %0d", pin_sel.name(), $time, v, pin_val);
          end
        end
      end
    end
  end

  task automatic tick(input exp_t e);
    @(posedge Clk);
    #1;
    pin_valid = 1'b0;
    exp_now   = e;
    exp_valid = 1'b1;
  endtask

  task automatic set_pin(input pin_e p, input int v);
    pin_sel = p; pin_val = v; pin_valid = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int max_steps, input int pin_step,
                           input pin_e p, input int v);
    int n;
    n = instr_len(op);
    if (max_steps < n) n = max_steps;
    for (int s = 0; s < n; s++) begin
      tick(model(op, m_prev, s, m_cnt, m_ill));
      if (s == 1) bus.Opcode = op;
      if (s == pin_step) set_pin(p, v);
    end
    if (n >= 2) m_prev = op;
    if (n == instr_len(op)) begin
      if (legal(op)) m_cnt = m_cnt + 1'b1;
      else m_ill = 1'b1;
    end
    $display("instr op=%b cycles=%0d model_retired=%0d model_illegal=%0d", op, n, m_cnt, m_ill);
  endtask

  // Hold reset for hold_cycles, then release into one IDLE cycle.
  task automatic reset_seq(input int hold_cycles);
    tick('0);
    Reset = 1'b0;
    set_pin(P_HALTED, 0);
    for (int i = 1; i < hold_cycles; i++) tick('0);
    tick('0);
    Reset = 1'b1;
    m_cnt = '0;
    m_ill = 1'b0;
  endtask

  initial begin
    bus.Opcode = 6'b000000;
    m_prev = 6'b000000;
    m_cnt  = '0;
    m_ill  = 1'b0;
    #1 Reset = 1'b0;
    reset_seq(3);

    run_instr(T_R,   99, 3, P_RFWRITE, 1);
    run_instr(T_LW,  99, 0, P_COUNT, 1);
    run_instr(T_SW,  99, 0, P_COUNT, 2);
    run_instr(T_BEQ, 99, 2, P_BEQ, 1);
    run_instr(T_BNE, 99, 2, P_BNE, 1);
    run_instr(T_BAD, 99, 0, P_COUNT, 5);
    run_instr(T_I,   99, 0, P_ILLEGAL, 1);
    run_instr(T_R,   99, 0, P_COUNT, 6);
    run_instr(T_HALT, 99, 2 + HALT_CYCLES - 1, P_HALTED, 1);
    reset_seq(2);

    // Abort a load in MEM_RD with an asynchronous reset mid-cycle.
    run_instr(T_LW, 4, 3, P_MDR, 1);
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    exp_now = '0;
    set_pin(P_MDR, 0);
    -> chk_ev;
    tick('0);
    tick('0);
    Reset = 1'b1;
    m_cnt = '0;
    m_ill = 1'b0;

    for (int i = 0; i < 16; i++) run_instr(T_J, 99, 0, P_COUNT, i);
    run_instr(T_R, 99, 0, P_COUNT, 0);

    @(negedge Clk);
    #1 exp_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences the team's multicycle MIPS datapath. It decodes the 6-bit `Opcode` returned by the datapath and drives every datapath control strobe and mux select, one instruction step per clock. It also keeps a retired-instruction counter and sticky halt/illegal-opcode status for the testbench and debug.

## Interface

**Parameters**
- `OpcodeSize`, 6: opcode width.
- `ALUOpSize`, 4: `AluOp` width.
- `CountSize`, 16: width of `InstrRetired`.

**Ports**
- `Clk`, input, 1: the single clock; all state changes on its rising edge.
- `Reset`, input, 1: asynchronous, active-low.
- `Opcode`, input, `OpcodeSize`: current IR opcode from the datapath.
- `PCSource`, `PCWrite`, `BEQcontrol`, `BNEcontrol`, output, 1 each: PC update controls.
- `AluOp`, output, `ALUOpSize`: ALU operation request.
- `AluSrcA`, output, 1: 0 = PC, 1 = A register.
- `AluSrcB`, output, 2: 0 = constant 1, 1 = B register, 2 = jump target SE, 3 = selected immediate.
- `IRWrite`, `RFWrite`, `MDRWrite`, `DMemWrite`, `MemToReg`, `ImmedAddr`, `ReadDataSrc1`, `ReadDataSrc2`, output, 1 each: datapath strobes and selects.
- `Halted`, output, 1: sticky; FSM is in HALT.
- `IllegalOp`, output, 1: sticky; an undefined opcode was decoded.
- `InstrRetired`, output, `CountSize`: count of completed instructions.

## Operation

**Opcode map**
- Class 2'b00: R-type ALU.
- Class 2'b01: I-type ALU.
- `LW` = 6'b100000, `SW` = 6'b100001.
- `BEQ` = 6'b110000, `BNE` = 6'b110001, `J` = 6'b110010, `HALT` = 6'b111111.
- Every other opcode in classes 10 and 11 is illegal.

**AluOp codes**
- `ADD` = 4'b0000, `SUB` = 4'b0001, `FUNC` = 4'b0010. `FUNC` tells the ALU controller to derive the operation from the instruction type.

**Default outputs**
- Every output not listed for a state below is 0.

**Register-read selects**
- `ReadDataSrc1` = 1 for class 00, class 01 and `LW`.
- `ReadDataSrc2` = 1 for class 00 only.
- Both are decoded from `Opcode` in every state except IDLE.

**States (4-bit encoding) and outputs**
- 0 IDLE: no outputs asserted. Goes to FETCH unconditionally.
- 1 FETCH: `IRWrite`, `PCWrite`, `AluSrcA`=0, `AluSrcB`=0, `AluOp`=ADD, `PCSource`=0. Next: DECODE.
- 2 DECODE: `AluSrcA`=0, `AluSrcB`=3, `AluOp`=ADD (branch target into AluOut). Next state:
  - class 00: EXEC_R
  - class 01: EXEC_I
  - `LW`/`SW`: MEM_ADDR
  - `BEQ`/`BNE`: BRANCH
  - `J`: JUMP
  - `HALT`: HALT
  - illegal: FETCH, and set `IllegalOp`
- 3 EXEC_R: `AluSrcA`=1, `AluSrcB`=1, `AluOp`=FUNC. Next: ALU_WB.
- 4 EXEC_I: `AluSrcA`=1, `AluSrcB`=3, `AluOp`=FUNC. Next: ALU_WB.
- 5 ALU_WB: `RFWrite`, `MemToReg`=0. Retires. Next: FETCH.
- 6 MEM_ADDR: `AluSrcA`=1, `AluSrcB`=3, `AluOp`=ADD. Next: MEM_RD for `LW`, MEM_WR for `SW`.
- 7 MEM_RD: `ImmedAddr`, `MDRWrite`. Next: MEM_WB.
- 8 MEM_WB: `RFWrite`, `MemToReg`=1. Retires. Next: FETCH.
- 9 MEM_WR: `ImmedAddr`, `DMemWrite`. Retires. Next: FETCH.
- 10 BRANCH: `AluSrcA`=1, `AluSrcB`=1, `AluOp`=SUB, `PCSource`=1, plus `BEQcontrol` for `BEQ` or `BNEcontrol` for `BNE`. Retires. Next: FETCH.
- 11 JUMP: `AluSrcA`=0, `AluSrcB`=2, `AluOp`=ADD, `PCWrite`, `PCSource`=0. Retires. Next: FETCH.
- 12 HALT: `Halted`=1. Stays here until `Reset`. Retires once, on entry.
- Unused encodings 13–15 go to IDLE.

**Retire counter**
- `InstrRetired` increments by 1 in the cycle after each retiring state.
- Wraps from all-ones to 0.
- Illegal opcodes are not counted.

## Timing

- **Reset (`Reset`=0):** state goes to IDLE immediately (asynchronous). All strobes and selects are 0, `Halted`=0, `IllegalOp`=0, `InstrRetired`=0.
- **Reset mid-instruction:** aborts the instruction. No strobe may be asserted in the reset cycle or in the first cycle after deassertion, which is IDLE.
- **Outputs:** pure Moore decode of the state register plus `Opcode`. They change only after a `Clk` edge or a reset assertion.
- **Cycles from FETCH entry to the next FETCH:**
  - R-type, I-type, SW: 4
  - LW: 5
  - BEQ, BNE, J: 3
  - illegal: 2
- **Opcode sampling:** `Opcode` is sampled only in DECODE, MEM_ADDR and BRANCH. The IR is stable there because `IRWrite` is asserted only in FETCH.
- **Mutual exclusion:** `PCWrite`, `BEQcontrol` and `BNEcontrol` are never asserted together. `RFWrite` and `DMemWrite` are never asserted together.

## Structure

- **Package `mips_ctrl_pkg`:**
  - state encoding constants
  - opcode constants (`LW`, `SW`, `BEQ`, `BNE`, `J`, `HALT`) and class codes
  - `AluOp` codes (`ADD`, `SUB`, `FUNC`)
  - `AluSrcB` select codes
- **Sub-module:** one natural sub-module, `ctrl_output_decode`, a combinational state+opcode to control-vector decoder. The FSM register, next-state logic, sticky flags and counter stay in the top module.

## Test plan

1. **Reset and first fetch:** hold `Reset`=0 for 3 cycles, then release. Every output is 0 during reset and in the first cycle after release (IDLE). FETCH follows, with `IRWrite`=`PCWrite`=1 and `AluSrcB`=0.
2. **R-type and LW sequencing:** `Opcode`=6'b000010.
   - States run FETCH, DECODE, EXEC_R, ALU_WB.
   - `RFWrite`=1 only in cycle 4; `ReadDataSrc1`=`ReadDataSrc2`=1 after FETCH; `InstrRetired` goes 0→1.
   - Repeat with `LW`: states run FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB.
   - `MemToReg`=1 and `RFWrite`=1 in cycle 5; `InstrRetired` reaches 2.
3. **SW and branches:**
   - `SW`: `DMemWrite`=1 in cycle 4 only, with `ImmedAddr`=1 and `RFWrite`=0.
   - `BEQ`: BRANCH cycle drives `BEQcontrol`=1, `BNEcontrol`=0, `AluOp`=SUB, `PCSource`=1.
   - `BNE`: BRANCH cycle drives the opposite `BEQcontrol`/`BNEcontrol` pair.
4. **Illegal opcode:** `Opcode`=6'b101111. DECODE goes to FETCH, `IllegalOp` rises and stays 1 through subsequent legal instructions, and `InstrRetired` is unchanged.
5. **HALT:** `Opcode`=6'b111111. `Halted`=1 and stays set for 20 cycles with all strobes 0 and `InstrRetired` incremented once. Asserting `Reset` clears `Halted`.
6. **Reset mid-instruction and counter wrap:**
   - Assert `Reset` during MEM_RD: `MDRWrite` drops in the same cycle, state returns to IDLE, and nothing is retired.
   - With `CountSize`=4, run 16 J instructions: `InstrRetired` wraps from 15 to 0.
